unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-ported unified memory between the instruction-fetch (IF) stage and the MEM stage of the 5-stage pipelined CPU. The block sequences each access over a req/ack memory handshake, captures returned data, and drives a single `stall` that freezes the PC and all pipeline registers until every pending access of the current cycle is complete. MEM-stage accesses have priority over IF. A watchdog flags a hung memory.

## Interface

Parameters:
- `TIMEOUT`, default 255: maximum number of cycles an access may wait for `m_ack`; range 1..1023.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `if_req` in 1: IF stage needs an instruction this cycle.
- `if_addr` in 32: instruction address (PC).
- `if_rdata` out 32: captured instruction word.
- `mem_read` in 1: load in the MEM stage.
- `mem_write` in 1: store in the MEM stage.
- `mem_addr` in 32: data address (ALU result).
- `mem_wdata` in 32: store data.
- `mem_rdata` out 32: captured load data.
- `stall` out 1: freeze the pipeline (combinational).
- `m_req` out 1: memory request (registered).
- `m_we` out 1: memory write enable (registered).
- `m_addr` out 32: memory address (registered).
- `m_wdata` out 32: memory write data (registered).
- `m_rdata` in 32: memory read data; valid only when `m_ack`=1.
- `m_ack` in 1: memory completes the access this cycle.
- `bus_error` out 1: sticky timeout flag.

## Operation

- **States:** IDLE, DATA, INST, ERROR.
- **Internal state:**
  - `d_served` and `i_served` flags.
  - Wait counter, 10 bits.
- **Derived signals:**
  - `d_pend` = (`mem_read` | `mem_write`) & !`d_served`.
  - `i_pend` = `if_req` & !`i_served`.
  - `stall` = (state==ERROR) | `d_pend` | `i_pend`.
- **IDLE:**
  - If `d_pend`: go to DATA. Load `m_addr`=`mem_addr`, `m_wdata`=`mem_wdata`, `m_we`=`mem_write`, `m_req`=1.
  - Else if `i_pend`: go to INST. Load `m_addr`=`if_addr`, `m_we`=0, `m_req`=1.
  - If `mem_read` and `mem_write` are both high, the access is a write.
- **DATA / INST:**
  - `m_req`, `m_we`, `m_addr` and `m_wdata` stay stable until `m_ack`.
  - On `m_ack`: go to IDLE and set `m_req`=0.
    - DATA: set `d_served`=1; if not a write, `mem_rdata`←`m_rdata`.
    - INST: set `i_served`=1 and `if_rdata`←`m_rdata`.
  - The wait counter increments each cycle without `m_ack`. If it reaches `TIMEOUT`, go to ERROR.
- **ERROR:**
  - `m_req`=0, `bus_error`=1, `stall`=1.
  - Only `reset` exits this state.
- **Pipeline advance:**
  - At any rising edge where `stall`=0, clear `d_served` and `i_served`. The pipeline advances on that same edge.
  - The served flags prevent a frozen MEM instruction from being re-accessed while the IF access is still outstanding, and vice versa.
- **Write data:** `mem_rdata` is not updated by writes.

## Timing

- **Reset values:**
  - State IDLE; served flags 0; counter 0.
  - `m_req`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0.
  - `if_rdata`=0, `mem_rdata`=0, `bus_error`=0.
  - `stall` follows `if_req`|`mem_read`|`mem_write` while in reset.
- **Issue latency:** a request seen in IDLE in cycle N raises `m_req` in cycle N+1.
- **Completion:**
  - `m_ack` in cycle K gives `m_req`=0 and the captured data in cycle K+1.
  - `stall` drops in K+1 if nothing else is pending.
- **Single access with zero-wait memory** (`m_ack` in the first `m_req` cycle): `stall` is high for 2 cycles.
- **Both pending:** the data access runs first, then IDLE for one cycle, then the IF access. With zero-wait memory `stall` is high for 4 cycles.
- **Bus gap:** at least one cycle of `m_req`=0 always separates two accesses.
- **Reset mid-access:** `m_req` drops immediately and the in-flight access is abandoned. The memory must tolerate a withdrawn request.
- **`m_ack` while `m_req`=0:** ignored.
- **Wait counter:** reset on entry to DATA or INST. A `m_ack` in the same cycle the count hits `TIMEOUT` completes the access normally; ack wins.

## Test plan

- **IF-only fetch:** `if_req`=1, `if_addr`=0x0040_0004, memory acks on its 3rd `m_req` cycle with 0x2008_0005.
  - `m_addr`=0x0040_0004 and `m_we`=0.
  - `if_rdata`=0x2008_0005 and `stall` low exactly 4 cycles after the request.
- **Load plus fetch, zero-wait memory:** `mem_read`=1, `mem_addr`=0x1000_0010, `if_req`=1.
  - The data access is issued first.
  - `mem_rdata` is captured, the IF access follows after one idle cycle, and `stall` is high for exactly 4 cycles.
  - Only one data access occurs.
- **Store priority:** `mem_read`=`mem_write`=1, `mem_wdata`=0xDEAD_BEEF.
  - `m_we`=1 and `m_wdata`=0xDEAD_BEEF.
  - `mem_rdata` is unchanged.
- **Timeout:** `TIMEOUT`=8, `m_ack` never asserted.
  - `bus_error`=1 and `m_req`=0 after 8 wait cycles.
  - `stall` stays 1 until `reset`.
- **Reset mid-access:** assert `reset` during DATA.
  - `m_req`=0 in the same cycle; all outputs at reset values.
  - After release, a new request is accepted normally.
- **Spurious ack:** pulse `m_ack` while IDLE.
  - No state change and no data capture.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single-ported unified memory between IF and MEM stages over a
// registered req/ack handshake; MEM has priority, and a watchdog traps hung accesses.
module unified_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        stall,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        bus_error
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StData  = 2'd1;
    localparam logic [1:0] StInst  = 2'd2;
    localparam logic [1:0] StError = 2'd3;

    localparam logic [9:0] TimeoutCnt = 10'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic        d_served_q, d_served_d;
    logic        i_served_q, i_served_d;
    logic [9:0]  wait_cnt_q, wait_cnt_d;
    logic [9:0]  wait_cnt_inc;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        bus_error_q, bus_error_d;
    logic        d_pend;
    logic        i_pend;

    assign d_pend       = (mem_read | mem_write) & ~d_served_q;
    assign i_pend       = if_req & ~i_served_q;
    assign stall        = (state_q == StError) | d_pend | i_pend;
    assign wait_cnt_inc = wait_cnt_q + 10'd1;

    always_comb begin
        state_d     = state_q;
        d_served_d  = d_served_q;
        i_served_d  = i_served_q;
        wait_cnt_d  = wait_cnt_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        bus_error_d = bus_error_q;

        case (state_q)
            StIdle: begin
                if (d_pend) begin
                    state_d    = StData;
                    m_req_d    = 1'b1;
                    m_we_d     = mem_write;
                    m_addr_d   = mem_addr;
                    m_wdata_d  = mem_wdata;
                    wait_cnt_d = 10'd0;
                end else if (i_pend) begin
                    state_d    = StInst;
                    m_req_d    = 1'b1;
                    m_we_d     = 1'b0;
                    m_addr_d   = if_addr;
                    wait_cnt_d = 10'd0;
                end
            end
            StData, StInst: begin
                // An ack in the cycle the watchdog would expire still completes.
                if (m_ack) begin
                    state_d = StIdle;
                    m_req_d = 1'b0;
                    if (state_q == StData) begin
                        d_served_d = 1'b1;
                        if (!m_we_q) begin
                            mem_rdata_d = m_rdata;
                        end
                    end else begin
                        i_served_d = 1'b1;
                        if_rdata_d = m_rdata;
                    end
                end else if (wait_cnt_inc == TimeoutCnt) begin
                    state_d     = StError;
                    m_req_d     = 1'b0;
                    bus_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            default: begin
                m_req_d     = 1'b0;
                bus_error_d = 1'b1;
            end
        endcase

        // The pipeline advances on any unstalled edge, so the next instruction
        // starts with fresh served flags.
        if (!stall) begin
            d_served_d = 1'b0;
            i_served_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            d_served_q  <= 1'b0;
            i_served_q  <= 1'b0;
            wait_cnt_q  <= 10'd0;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= 32'd0;
            m_wdata_q   <= 32'd0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_served_q  <= d_served_d;
            i_served_q  <= i_served_d;
            wait_cnt_q  <= wait_cnt_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: the bench plays the memory, driving
// m_ack/m_rdata cycle by cycle, and checks each step against hand-computed values.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        bus_error;

    int nvec;
    int nerr;
    int n_acks;
    int acks_before;

    unified_mem_arbiter #(
        .TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall    (stall),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .bus_error(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completed handshakes, used to prove a frozen load is not re-issued.
    initial n_acks = 0;
    always @(posedge clk) begin
        if (m_req && m_ack) n_acks <= n_acks + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        m_rdata   = 32'd0;
        m_ack     = 1'b0;

        // Reset values
        #2;
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_stall_idle", 32'(stall), 32'd0);
        if_req = 1'b1;
        #1;
        chk("rst_stall_follows_req", 32'(stall), 32'd1);
        if_req = 1'b0;

        cyc();
        reset = 1'b0;

        // IF-only fetch, ack on the 3rd m_req cycle
        cyc(); if_req = 1'b1; if_addr = 32'h0040_0004; #1;
        chk("if_stall_n", 32'(stall), 32'd1);
        chk("if_req_latency", 32'(m_req), 32'd0);
        cyc(); #1;
        chk("if_m_req", 32'(m_req), 32'd1);
        chk("if_m_addr", m_addr, 32'h0040_0004);
        chk("if_m_we", 32'(m_we), 32'd0);
        cyc(); #1;
        chk("if_m_req_hold", 32'(m_req), 32'd1);
        cyc(); m_ack = 1'b1; m_rdata = 32'h2008_0005; #1;
        chk("if_stall_wait", 32'(stall), 32'd1);
        cyc(); m_ack = 1'b0; m_rdata = 32'd0; #1;
        chk("if_rdata", if_rdata, 32'h2008_0005);
        chk("if_stall_drop", 32'(stall), 32'd0);
        chk("if_m_req_drop", 32'(m_req), 32'd0);
        cyc(); if_req = 1'b0; #1;
        chk("if_no_reissue", 32'(m_req), 32'd0);

        // Load plus fetch, zero-wait memory
        acks_before = n_acks;
        cyc(); mem_read = 1'b1; mem_addr = 32'h1000_0010;
        if_req = 1'b1; if_addr = 32'h0040_0008; #1;
        chk("lf_stall_1", 32'(stall), 32'd1);
        cyc(); m_ack = 1'b1; m_rdata = 32'hAAAA_0001; #1;
        chk("lf_data_first", m_addr, 32'h1000_0010);
        chk("lf_data_rd", 32'(m_we), 32'd0);
        chk("lf_stall_2", 32'(stall), 32'd1);
        cyc(); m_ack = 1'b0; m_rdata = 32'd0; #1;
        chk("lf_gap", 32'(m_req), 32'd0);
        chk("lf_mem_rdata", mem_rdata, 32'hAAAA_0001);
        chk("lf_stall_3", 32'(stall), 32'd1);
        cyc(); m_ack = 1'b1; m_rdata = 32'hBBBB_0002; #1;
        chk("lf_inst_req", 32'(m_req), 32'd1);
        chk("lf_inst_addr", m_addr, 32'h0040_0008);
        chk("lf_stall_4", 32'(stall), 32'd1);
        cyc(); m_ack = 1'b0; m_rdata = 32'd0; #1;
        chk("lf_if_rdata", if_rdata, 32'hBBBB_0002);
        chk("lf_stall_end", 32'(stall), 32'd0);
        chk("lf_mem_rdata_kept", mem_rdata, 32'hAAAA_0001);
        cyc(); mem_read = 1'b0; if_req = 1'b0; #1;
        chk("lf_no_reissue", 32'(m_req), 32'd0);
        chk("lf_ack_count", 32'(n_acks - acks_before), 32'd2);

        // Store priority when read and write are both asserted
        cyc(); mem_read = 1'b1; mem_write = 1'b1;
        mem_addr = 32'h1000_0020; mem_wdata = 32'hDEAD_BEEF; #1;
        chk("st_stall", 32'(stall), 32'd1);
        cyc(); m_ack = 1'b1; m_rdata = 32'h1234_5678; #1;
        chk("st_m_we", 32'(m_we), 32'd1);
        chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("st_m_addr", m_addr, 32'h1000_0020);
        cyc(); m_ack = 1'b0; m_rdata = 32'd0; #1;
        chk("st_mem_rdata_kept", mem_rdata, 32'hAAAA_0001);
        chk("st_stall_end", 32'(stall), 32'd0);
        cyc(); mem_read = 1'b0; mem_write = 1'b0; #1;
        chk("st_idle", 32'(m_req), 32'd0);

        // Spurious ack while idle
        cyc(); m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF; #1;
        cyc(); m_ack = 1'b0; m_rdata = 32'd0; #1;
        chk("sp_m_req", 32'(m_req), 32'd0);
        chk("sp_if_rdata", if_rdata, 32'hBBBB_0002);
        chk("sp_mem_rdata", mem_rdata, 32'hAAAA_0001);
        chk("sp_stall", 32'(stall), 32'd0);

        // Ack on the 8th m_req cycle, where the watchdog would otherwise expire
        cyc(); mem_read = 1'b1; mem_addr = 32'h1000_0030; #1;
        for (int i = 1; i <= 7; i++) begin
            cyc(); #1;
            chk("aw_m_req_wait", 32'(m_req), 32'd1);
        end
        cyc(); m_ack = 1'b1; m_rdata = 32'hCAFE_0008; #1;
        chk("aw_m_req_8", 32'(m_req), 32'd1);
        chk("aw_no_err_8", 32'(bus_error), 32'd0);
        cyc(); m_ack = 1'b0; m_rdata = 32'd0; #1;
        chk("aw_mem_rdata", mem_rdata, 32'hCAFE_0008);
        chk("aw_bus_error", 32'(bus_error), 32'd0);
        chk("aw_stall_end", 32'(stall), 32'd0);
        cyc(); mem_read = 1'b0; #1;

        // Reset during a data access
        cyc(); mem_read = 1'b1; mem_addr = 32'h1000_0040; #1;
        cyc(); #1;
        chk("rm_m_req_before", 32'(m_req), 32'd1);
        #1; reset = 1'b1; #1;
        chk("rm_m_req_drop", 32'(m_req), 32'd0);
        chk("rm_m_addr", m_addr, 32'd0);
        chk("rm_mem_rdata", mem_rdata, 32'd0);
        chk("rm_if_rdata", if_rdata, 32'd0);
        chk("rm_stall", 32'(stall), 32'd1);
        cyc(); reset = 1'b0; #1;
        chk("rm_restart_wait", 32'(m_req), 32'd0);
        cyc(); m_ack = 1'b1; m_rdata = 32'h0BAD_0001; #1;
        chk("rm_reissue", 32'(m_req), 32'd1);
        chk("rm_reissue_addr", m_addr, 32'h1000_0040);
        cyc(); m_ack = 1'b0; m_rdata = 32'd0; #1;
        chk("rm_mem_rdata_new", mem_rdata, 32'h0BAD_0001);
        chk("rm_stall_end", 32'(stall), 32'd0);
        cyc(); mem_read = 1'b0; #1;

        // Timeout: no ack ever
        cyc(); if_req = 1'b1; if_addr = 32'h0040_000C; #1;
        for (int i = 1; i <= 8; i++) begin
            cyc(); #1;
            chk("to_m_req_wait", 32'(m_req), 32'd1);
            chk("to_no_err_yet", 32'(bus_error), 32'd0);
        end
        cyc(); #1;
        chk("to_bus_error", 32'(bus_error), 32'd1);
        chk("to_m_req_drop", 32'(m_req), 32'd0);
        chk("to_stall", 32'(stall), 32'd1);
        cyc(); if_req = 1'b0; m_ack = 1'b1; #1;
        cyc(); m_ack = 1'b0; #1;
        chk("to_stall_sticky", 32'(stall), 32'd1);
        chk("to_err_sticky", 32'(bus_error), 32'd1);
        chk("to_m_req_stays", 32'(m_req), 32'd0);
        reset = 1'b1; #1;
        chk("to_reset_err", 32'(bus_error), 32'd0);
        chk("to_reset_stall", 32'(stall), 32'd0);
        cyc(); reset = 1'b0; #1;
        chk("to_after_reset", 32'(stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
